// File: rtl/ysyx_22041071_hazard_ctrl.sv
// ID->EX hazard scheduler: in-flight dest tracker, forward selects, load-use bubbles, redirect flush.
// Optional perf counters are built when YSYX_22041071_HZD_PERF_EN is defined.
module ysyx_22041071_hazard_ctrl #(
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned FLUSH_CYC = 1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
`ifdef YSYX_22041071_HZD_PERF_EN
  output logic [CNT_W-1:0]  perf_stall_cyc,
  output logic [CNT_W-1:0]  perf_flush_cnt,
`endif
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wen,
  input  logic              id_is_load,
  input  logic              ex_ready,
  input  logic              br_taken,
  output logic              id_ready,
  output logic              issue,
  output logic              ex_bubble,
  output logic [1:0]        fwd_sel1,
  output logic [1:0]        fwd_sel2,
  output logic              if_flush,
  output logic              stall_lu
);

  localparam int unsigned CntW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(FLUSH_CYC - 1);

  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  // Tracker slot 0 = EX, 1 = MEM, 2 = WB.
  logic [2:0]        r_tk_v;
  logic [2:0]        r_tk_ld;
  logic [REG_AW-1:0] r_tk_rd [3];
  logic [0:0]        r_state;
  logic [CntW-1:0]   r_cnt;

  logic [0:0]        w_state_nxt;
  logic [CntW-1:0]   w_cnt_nxt;
  logic [2:0]        w_m1;
  logic [2:0]        w_m2;
  logic              w_run;
  logic              w_stall;
  logic              w_ready;
  logic              w_issue;
  logic              w_new_v;

  function automatic logic [1:0] sel_of(input logic [2:0] m);
    if (m[0])      return 2'd1;
    else if (m[1]) return 2'd2;
    else if (m[2]) return 2'd3;
    else           return 2'd0;
  endfunction

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_m1[k] = id_rs1_used && (id_rs1 != '0) && r_tk_v[k] && (r_tk_rd[k] == id_rs1);
      w_m2[k] = id_rs2_used && (id_rs2 != '0) && r_tk_v[k] && (r_tk_rd[k] == id_rs2);
    end
  end

  assign w_run   = (r_state == S_RUN);
  assign w_stall = id_valid & (w_m1[0] | w_m2[0]) & r_tk_ld[0];
  assign w_ready = w_run & ~br_taken & ~w_stall & ex_ready;
  assign w_issue = id_valid & w_ready;
  assign w_new_v = w_issue & id_wen & (id_rd != '0);

  // All outputs are forced quiet while reset is held.
  assign id_ready  = reset & w_ready;
  assign issue     = reset & w_issue;
  assign ex_bubble = reset & ex_ready & ~w_issue;
  assign fwd_sel1  = (reset & id_valid) ? sel_of(w_m1) : 2'd0;
  assign fwd_sel2  = (reset & id_valid) ? sel_of(w_m2) : 2'd0;
  assign if_flush  = reset & (br_taken | ~w_run);
  assign stall_lu  = reset & w_stall;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (br_taken) begin
      w_state_nxt = S_FLUSH;
      w_cnt_nxt   = CntInit;
    end else if ((r_state == S_FLUSH) && ex_ready) begin
      if (r_cnt == '0) w_state_nxt = S_RUN;
      else             w_cnt_nxt   = r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tk_v  <= '0;
      r_tk_ld <= '0;
      for (int k = 0; k < 3; k++) r_tk_rd[k] <= '0;
    end else if (ex_ready) begin
      r_tk_v     <= {r_tk_v[1:0], w_new_v};
      r_tk_ld    <= {r_tk_ld[1:0], w_new_v & id_is_load};
      r_tk_rd[2] <= r_tk_rd[1];
      r_tk_rd[1] <= r_tk_rd[0];
      r_tk_rd[0] <= w_new_v ? id_rd : '0;
    end
  end

`ifdef YSYX_22041071_HZD_PERF_EN
  logic [CNT_W-1:0] r_stall_cyc;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cyc <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (id_valid && !w_ready && !(&r_stall_cyc)) r_stall_cyc <= r_stall_cyc + 1'b1;
      if (br_taken && !(&r_flush_cnt))             r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign perf_stall_cyc = r_stall_cyc;
  assign perf_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_ysyx_22041071_hazard_ctrl.sv
// Bench for ysyx_22041071_hazard_ctrl: directed scenarios plus random traffic against a reference model.
module tb_ysyx_22041071_hazard_ctrl;

  localparam int FC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_rs1_used, id_rs2_used, id_wen, id_is_load, ex_ready, br_taken;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_ready, issue, ex_bubble, if_flush, stall_lu;
  logic [1:0] fwd_sel1, fwd_sel2;
`ifdef YSYX_22041071_HZD_PERF_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt;
`endif

  ysyx_22041071_hazard_ctrl #(.REG_AW(5), .FLUSH_CYC(FC), .CNT_W(32)) u_dut (
    .clk         (clk),
    .reset       (reset),
`ifdef YSYX_22041071_HZD_PERF_EN
    .perf_stall_cyc (perf_stall_cyc),
    .perf_flush_cnt (perf_flush_cnt),
`endif
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rd       (id_rd),
    .id_wen      (id_wen),
    .id_is_load  (id_is_load),
    .ex_ready    (ex_ready),
    .br_taken    (br_taken),
    .id_ready    (id_ready),
    .issue       (issue),
    .ex_bubble   (ex_bubble),
    .fwd_sel1    (fwd_sel1),
    .fwd_sel2    (fwd_sel2),
    .if_flush    (if_flush),
    .stall_lu    (stall_lu)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: list of producers by age and number of killed cycles left.
  bit  m_v  [3];
  int  m_rd [3];
  bit  m_ld [3];
  int  flush_left;
  int  m_stall_cyc, m_flush_cnt;
  bit  e_ready, e_issue, e_bub, e_flush, e_stall;
  int  e_sel1, e_sel2;

  function automatic int src_of(input bit used, input int rs);
    if (!used || rs == 0) return 0;
    for (int k = 0; k < 3; k++) if (m_v[k] && m_rd[k] == rs) return k + 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin m_v[k] = 0; m_rd[k] = 0; m_ld[k] = 0; end
    flush_left  = 0;
    m_stall_cyc = 0;
    m_flush_cnt = 0;
  endtask

  task automatic set_in(input bit v, input int r1, input int r2, input bit u1, input bit u2,
                        input int rd, input bit wen, input bit ld, input bit exr, input bit br);
    id_valid = v; id_rs1 = 5'(r1); id_rs2 = 5'(r2); id_rs1_used = u1; id_rs2_used = u2;
    id_rd = 5'(rd); id_wen = wen; id_is_load = ld; ex_ready = exr; br_taken = br;
  endtask

  task automatic eval();
    @(negedge clk);
    if (!reset) begin
      e_ready = 0; e_issue = 0; e_bub = 0; e_flush = 0; e_stall = 0; e_sel1 = 0; e_sel2 = 0;
    end else begin
      e_sel1  = id_valid ? src_of(id_rs1_used, int'(id_rs1)) : 0;
      e_sel2  = id_valid ? src_of(id_rs2_used, int'(id_rs2)) : 0;
      e_stall = id_valid && m_ld[0] && (e_sel1 == 1 || e_sel2 == 1);
      e_ready = (flush_left == 0) && !br_taken && !e_stall && ex_ready;
      e_issue = id_valid && e_ready;
      e_bub   = ex_ready && !e_issue;
      e_flush = br_taken || flush_left > 0;
    end
    chk("id_ready", id_ready, e_ready);
    chk("issue", issue, e_issue);
    chk("ex_bubble", ex_bubble, e_bub);
    chk("fwd_sel1", fwd_sel1, e_sel1);
    chk("fwd_sel2", fwd_sel2, e_sel2);
    chk("if_flush", if_flush, e_flush);
    chk("stall_lu", stall_lu, e_stall);
`ifdef YSYX_22041071_HZD_PERF_EN
    chk("perf_stall", perf_stall_cyc, m_stall_cyc);
    chk("perf_flush", perf_flush_cnt, m_flush_cnt);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_reset();
    else begin
      if (id_valid && !e_ready) m_stall_cyc++;
      if (br_taken) m_flush_cnt++;
      if (ex_ready) begin
        for (int k = 2; k > 0; k--) begin m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_ld[k] = m_ld[k-1]; end
        m_v[0]  = e_issue && id_wen && id_rd != 0;
        m_rd[0] = int'(id_rd);
        m_ld[0] = id_is_load;
      end
      if (br_taken) flush_left = FC;
      else if (flush_left > 0 && ex_ready) flush_left--;
    end
    #1;
  endtask

  initial begin
    model_reset();
    reset = 1'b0;
    set_in(1, 5, 5, 1, 1, 5, 1, 1, 1, 0);
    eval(); step();
    eval(); step();
    reset = 1'b1;

    // Load x5, then dependent add stalls one cycle, then forwards from MEM.
    set_in(1, 0, 0, 0, 0, 5, 1, 1, 1, 0);
    eval(); chk("s1_ld_issue", issue, 1); step();
    set_in(1, 5, 1, 1, 1, 6, 1, 0, 1, 0);
    eval(); chk("s1_stall", stall_lu, 1); chk("s1_bub", ex_bubble, 1); step();
    eval(); chk("s1_fwd_mem", fwd_sel1, 2); chk("s1_issue", issue, 1); step();

    // ALU producer x7 forwarded from EX, MEM and WB.
    set_in(1, 0, 0, 0, 0, 7, 1, 0, 1, 0);
    eval(); step();
    set_in(1, 7, 7, 1, 1, 8, 1, 0, 1, 0);
    eval(); chk("s2_ex1", fwd_sel1, 1); chk("s2_ex2", fwd_sel2, 1); step();
    set_in(1, 7, 0, 1, 0, 9, 1, 0, 1, 0);
    eval(); chk("s2_mem", fwd_sel1, 2); step();
    set_in(1, 0, 7, 0, 1, 10, 1, 0, 1, 0);
    eval(); chk("s2_wb", fwd_sel2, 3); step();

    // x0 is never tracked.
    set_in(1, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    eval(); step();
    set_in(1, 0, 0, 1, 1, 11, 1, 0, 1, 0);
    eval(); chk("s3_x0", fwd_sel1, 0); chk("s3_nostall", stall_lu, 0); step();

    // Redirect: pulse plus FC killed cycles.
    set_in(1, 1, 2, 1, 1, 12, 1, 0, 1, 1);
    eval(); chk("s4_pulse", if_flush, 1); step();
    set_in(1, 1, 2, 1, 1, 12, 1, 0, 1, 0);
    for (int i = 0; i < FC; i++) begin
      eval(); chk("s4_flush", if_flush, 1); chk("s4_rdy", id_ready, 0); step();
    end
    eval(); chk("s4_done", if_flush, 0); step();

    // Branch coincident with load-use stall.
    set_in(1, 0, 0, 0, 0, 5, 1, 1, 1, 0);
    eval(); step();
    set_in(1, 5, 0, 1, 0, 6, 1, 0, 1, 1);
    eval(); chk("s5_issue", issue, 0); step();
    set_in(1, 5, 0, 1, 0, 6, 1, 0, 1, 0);
    for (int i = 0; i < FC; i++) begin eval(); step(); end
    eval(); chk("s5_nostale", stall_lu, 0); chk("s5_issue2", issue, 1); step();

    // Fill the tracker, redirect, then assert reset mid-flush.
    for (int i = 1; i <= 3; i++) begin
      set_in(1, 0, 0, 0, 0, i, 1, 0, 1, 0);
      eval(); step();
    end
    set_in(1, 1, 2, 1, 1, 4, 1, 0, 1, 1);
    eval(); step();
    set_in(1, 1, 2, 1, 1, 4, 1, 0, 1, 0);
    reset = 1'b0;
    #1;
    chk("s6_flush0", if_flush, 0); chk("s6_sel0", fwd_sel1, 0); chk("s6_bub0", ex_bubble, 0);
    eval(); step();
    reset = 1'b1;
    eval(); chk("s6_ready", id_ready, 1); chk("s6_fwd", fwd_sel2, 0); step();

    // Random traffic with a small register window to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(63) != 0);
      set_in($urandom_range(4) != 0, $urandom_range(7), $urandom_range(7),
             $urandom_range(1), $urandom_range(1), $urandom_range(7),
             $urandom_range(3) != 0, $urandom_range(2) == 0,
             $urandom_range(3) != 0, $urandom_range(9) == 0);
      eval(); step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
